// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, done encoding and FSM state type for the fetch unit
package fetch_pkg;

  localparam int PC_W = 8;
  localparam int IW = 9;
  localparam int CNT_W = 16;
  localparam logic [IW-1:0] DONE_WORD = 9'b000_000_000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with async and sync clear
// Ports:
//   clk, rst_n : clock, asynchronous active-low clear
//   clr        : synchronous clear, wins over inc
//   inc        : count up by one, holding at all-ones
//   count      : current value
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer with decode handshake, redirect and halt
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start, start_pc      : begin fetching at start_pc (from IDLE or HALT)
//   PC, iptr             : address out to / word back from combinational instruction memory
//   inst, inst_pc        : registered instruction and its address to decode
//   inst_valid/inst_ready: decode handshake
//   br_taken, br_target  : redirect, qualified by the handshake
//   busy, halted         : state is RUN / HALT
//   retired              : saturating count of handshakes since the last start
module fetch_unit #(
  parameter int                PC_W      = fetch_pkg::PC_W,
  parameter int                IW        = fetch_pkg::IW,
  parameter logic [IW-1:0]     DONE_WORD = fetch_pkg::DONE_WORD,
  parameter int                CNT_W     = fetch_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PC_W-1:0]  start_pc,
  output logic [PC_W-1:0]  PC,
  input  logic [IW-1:0]    iptr,
  output logic [IW-1:0]    inst,
  output logic [PC_W-1:0]  inst_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_target,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  import fetch_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IW-1:0]   inst_q, inst_d;
  logic [PC_W-1:0] inst_pc_q, inst_pc_d;
  logic            valid_q, valid_d;

  logic handshake;
  logic restart;

  assign handshake = valid_q & inst_ready;
  // start only takes effect outside RUN; it also clears the retired count
  assign restart   = start & (state_q != RUN);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = start_pc;
          valid_d = 1'b0;
        end
      end
      RUN: begin
        if (handshake && br_taken) begin
          // redirect drops the fall-through word and beats the done check
          pc_d    = br_target;
          valid_d = 1'b0;
        end else if (!valid_q || inst_ready) begin
          inst_d    = iptr;
          inst_pc_d = pc_q;
          valid_d   = 1'b1;
          if (iptr == DONE_WORD) begin
            state_d = HALT;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      HALT: begin
        if (start) begin
          state_d = RUN;
          pc_d    = start_pc;
          valid_d = 1'b0;
        end else if (handshake) begin
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_retired (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (restart),
    .inc   (handshake),
    .count (retired)
  );

  assign PC         = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = valid_q;
  assign busy       = (state_q == RUN);
  assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  start_pc;
  logic [7:0]  pc;
  logic [8:0]  iptr;
  logic [8:0]  inst;
  logic [7:0]  inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        br_taken;
  logic [7:0]  br_target;
  logic        busy;
  logic        halted;
  logic [15:0] retired;

  logic [8:0]  mem [256];
  int          checks;
  int          errors;

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_pc   (start_pc),
    .PC         (pc),
    .iptr       (iptr),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .busy       (busy),
    .halted     (halted),
    .retired    (retired)
  );

  assign iptr = mem[pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: done words at 27 (end of multiply program) and 40
  function automatic logic [8:0] word_at(input int a);
    if (a == 27 || a == 40) return 9'h000;
    return 9'h100 | 9'(a & 8'hff);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pc"}, 32'(pc), 0);
    chk({tag, "_inst"}, 32'(inst), 0);
    chk({tag, "_inst_pc"}, 32'(inst_pc), 0);
    chk({tag, "_valid"}, 32'(inst_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_halted"}, 32'(halted), 0);
    chk({tag, "_retired"}, 32'(retired), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = word_at(i);
    rst_n = 1'b0; start = 1'b0; start_pc = 8'd0;
    inst_ready = 1'b0; br_taken = 1'b0; br_target = 8'd0;

    // reset state
    step(); step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 0);

    // program at 0 runs to done at 27
    start = 1'b1; start_pc = 8'd0; inst_ready = 1'b1;
    step();
    start = 1'b0;
    chk("start_pc", 32'(pc), 0);
    chk("start_valid", 32'(inst_valid), 0);
    chk("start_busy", 32'(busy), 1);
    for (int k = 0; k < 28; k++) begin
      step();
      chk("run_valid", 32'(inst_valid), 1);
      chk("run_inst_pc", 32'(inst_pc), 32'(k));
      chk("run_inst", 32'(inst), 32'(word_at(k)));
      chk("run_pc", 32'(pc), (k == 27) ? 32'd27 : 32'(k + 1));
    end
    chk("done_halted", 32'(halted), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_retired", 32'(retired), 27);
    step();
    chk("halt_valid", 32'(inst_valid), 0);
    chk("halt_retired", 32'(retired), 28);
    chk("halt_pc", 32'(pc), 27);
    step();
    chk("halt_hold_pc", 32'(pc), 27);

    // backpressure from 28
    start = 1'b1; start_pc = 8'd28;
    step();
    start = 1'b0;
    chk("bp_start_pc", 32'(pc), 28);
    chk("bp_retired_clr", 32'(retired), 0);
    step();
    chk("bp_first_pc", 32'(inst_pc), 28);
    inst_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_inst_pc", 32'(inst_pc), 28);
      chk("bp_inst", 32'(inst), 32'(word_at(28)));
      chk("bp_pc", 32'(pc), 29);
      chk("bp_retired", 32'(retired), 0);
      chk("bp_valid", 32'(inst_valid), 1);
    end
    inst_ready = 1'b1;
    step();
    chk("bp_resume_inst_pc", 32'(inst_pc), 29);
    chk("bp_resume_pc", 32'(pc), 30);
    chk("bp_resume_retired", 32'(retired), 1);

    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async");
    step();
    rst_n = 1'b1;

    // branch at 16 to 2
    start = 1'b1; start_pc = 8'd0; inst_ready = 1'b1;
    step();
    start = 1'b0;
    chk("br_start_pc", 32'(pc), 0);
    for (int k = 0; k < 17; k++) step();
    chk("br_at16", 32'(inst_pc), 16);
    br_taken = 1'b1; br_target = 8'd2;
    step();
    br_taken = 1'b0;
    chk("br_pc", 32'(pc), 2);
    chk("br_bubble", 32'(inst_valid), 0);
    chk("br_retired", 32'(retired), 17);
    step();
    chk("br_tgt_valid", 32'(inst_valid), 1);
    chk("br_tgt_inst_pc", 32'(inst_pc), 2);
    chk("br_tgt_pc", 32'(pc), 3);

    // branch versus done: handshake of 26 while PC=27 fetches the done word
    for (int k = 0; k < 24; k++) step();
    chk("bd_inst_pc", 32'(inst_pc), 26);
    chk("bd_pc", 32'(pc), 27);
    br_taken = 1'b1; br_target = 8'd5;
    step();
    br_taken = 1'b0;
    chk("bd_pc_redirect", 32'(pc), 5);
    chk("bd_valid", 32'(inst_valid), 0);
    chk("bd_busy", 32'(busy), 1);
    chk("bd_halted", 32'(halted), 0);
    step();
    chk("bd_tgt_inst_pc", 32'(inst_pc), 5);

    // wrap and unqualified branch
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    start = 1'b1; start_pc = 8'd254;
    step();
    start = 1'b0;
    chk("wr_pc0", 32'(pc), 254);
    step();
    chk("wr_inst_pc0", 32'(inst_pc), 254);
    chk("wr_pc1", 32'(pc), 255);
    inst_ready = 1'b0; br_taken = 1'b1; br_target = 8'd9;
    step();
    chk("uq_inst_pc", 32'(inst_pc), 254);
    chk("uq_pc", 32'(pc), 255);
    chk("uq_valid", 32'(inst_valid), 1);
    br_taken = 1'b0; inst_ready = 1'b1;
    step();
    chk("wr_inst_pc1", 32'(inst_pc), 255);
    chk("wr_pc2", 32'(pc), 0);
    step();
    chk("wr_inst_pc2", 32'(inst_pc), 0);
    chk("wr_inst2", 32'(inst), 32'(word_at(0)));
    chk("wr_pc3", 32'(pc), 1);
    chk("wr_retired", 32'(retired), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
